// File: rtl/vga_ball_engine_if.sv
// Video-side bundle between the VGA timing generator and the ball engine:
// raster position, video-active flag, frame refresh level and the RGB pins.
interface vga_ball_engine_if;
  logic [9:0] h;
  logic [9:0] v;
  logic       von;
  logic       refresh;
  logic [7:0] rgb;

  modport master (output h, v, von, refresh, input rgb);
  modport slave  (input h, v, von, refresh, output rgb);
endinterface

// File: rtl/vga_ball_engine.sv
// Bouncing-ball game engine: per-frame ball motion, serve/pause/miss FSM and a
// registered pixel stage that paints ball, border and background.
module vga_ball_engine #(
  parameter int         SIZE        = 8,
  parameter int         SPEED       = 2,
  parameter int         BORDER      = 4,
  parameter int         MISS_FRAMES = 60,
  parameter logic [7:0] C_BALL      = 8'hFF,
  parameter logic [7:0] C_BORDER    = 8'h1C,
  parameter logic [7:0] C_BG        = 8'h00
) (
  input  logic               clk,
  input  logic               clr,
  vga_ball_engine_if.slave   vid,
  input  logic               btn_serve,
  input  logic               btn_pause,
  output logic               hit,
  output logic               miss,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y
);

  localparam int XMIN = BORDER;
  localparam int XMAX = 640 - BORDER - SIZE;
  localparam int YMIN = BORDER;
  localparam int YMAX = 480 - SIZE;
  localparam int XH   = (640 - SIZE) / 2;
  localparam int YH   = (480 - SIZE) / 2;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, MISS} state_t;

  state_t      state, nstate;
  logic        dir_x, dir_y, ndir_x, ndir_y;
  logic [9:0]  nx, ny;
  logic [7:0]  cnt, ncnt;
  logic        nhit, nmiss;
  logic        refresh_d, tick;
  logic [1:0]  serve_s, pause_s;
  logic        serve_d, pause_d, serve_p, pause_p;
  logic [10:0] x11, y11, h11, v11;
  logic        in_ball, in_border, show;
  logic [7:0]  pix;

  assign tick = vid.refresh & ~refresh_d;
  assign x11  = {1'b0, ball_x};
  assign y11  = {1'b0, ball_y};
  assign h11  = {1'b0, vid.h};
  assign v11  = {1'b0, vid.v};

  // Two-flop synchronizers followed by registered rising-edge detectors.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      refresh_d <= 1'b0;
      serve_s   <= 2'b00;
      pause_s   <= 2'b00;
      serve_d   <= 1'b0;
      pause_d   <= 1'b0;
      serve_p   <= 1'b0;
      pause_p   <= 1'b0;
    end else begin
      refresh_d <= vid.refresh;
      serve_s   <= {serve_s[0], btn_serve};
      pause_s   <= {pause_s[0], btn_pause};
      serve_d   <= serve_s[1];
      pause_d   <= pause_s[1];
      serve_p   <= serve_s[1] & ~serve_d;
      pause_p   <= pause_s[1] & ~pause_d;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      ball_x <= 10'(XH);
      ball_y <= 10'(YH);
      dir_x  <= 1'b1;
      dir_y  <= 1'b1;
      cnt    <= 8'd0;
      hit    <= 1'b0;
      miss   <= 1'b0;
    end else begin
      state  <= nstate;
      ball_x <= nx;
      ball_y <= ny;
      dir_x  <= ndir_x;
      dir_y  <= ndir_y;
      cnt    <= ncnt;
      hit    <= nhit;
      miss   <= nmiss;
    end
  end

  // dir_x = 1 means moving right, dir_y = 1 means moving up.
  always_comb begin
    nstate = state;
    nx     = ball_x;
    ny     = ball_y;
    ndir_x = dir_x;
    ndir_y = dir_y;
    ncnt   = cnt;
    nhit   = 1'b0;
    nmiss  = 1'b0;
    case (state)
      IDLE: if (serve_p) nstate = RUN;
      RUN: begin
        if (tick) begin
          if (dir_x) begin
            if (x11 >= 11'(XMAX - SPEED)) begin
              nx = 10'(XMAX); ndir_x = 1'b0; nhit = 1'b1;
            end else nx = ball_x + 10'(SPEED);
          end else begin
            if (x11 <= 11'(XMIN + SPEED)) begin
              nx = 10'(XMIN); ndir_x = 1'b1; nhit = 1'b1;
            end else nx = ball_x - 10'(SPEED);
          end
          if (dir_y) begin
            if (y11 <= 11'(YMIN + SPEED)) begin
              ny = 10'(YMIN); ndir_y = 1'b0; nhit = 1'b1;
            end else ny = ball_y - 10'(SPEED);
          end else begin
            if (y11 >= 11'(YMAX - SPEED)) begin
              ny = 10'(YMAX); nmiss = 1'b1; nstate = MISS;
            end else ny = ball_y + 10'(SPEED);
          end
        end
        if (pause_p && !nmiss) nstate = PAUSE;
      end
      PAUSE: if (pause_p) nstate = RUN;
      MISS: begin
        if (tick) begin
          if (cnt == 8'(MISS_FRAMES - 1)) begin
            ncnt   = 8'd0;
            nx     = 10'(XH);
            ny     = 10'(YH);
            ndir_x = 1'b1;
            ndir_y = 1'b1;
            nstate = IDLE;
          end else ncnt = cnt + 8'd1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // During MISS the ball blinks on counter bit 3.
  always_comb begin
    in_ball   = (h11 >= x11) && (h11 < x11 + 11'(SIZE)) &&
                (v11 >= y11) && (v11 < y11 + 11'(SIZE));
    in_border = (h11 < 11'(BORDER)) || (h11 >= 11'(640 - BORDER)) ||
                (v11 < 11'(BORDER));
    show      = !((state == MISS) && cnt[3]);
    pix       = C_BG;
    if (!vid.von)             pix = 8'h00;
    else if (in_ball && show) pix = C_BALL;
    else if (in_border)       pix = C_BORDER;
    else                      pix = C_BG;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) vid.rgb <= 8'h00;
    else     vid.rgb <= pix;
  end

endmodule
